enkel_core_p: RTL

- Parametrised multi-cycle accumulator CPU core. It is the next generation of the 8-bit enkel computer datapath and control.
- Fetches single-word instructions from an external memory through a req/ack handshake that supports any number of wait states. Executes a 4-bit opcode set with ADD/SUB, carry and zero flags, and conditional jumps.
- Adds a halt-at-instruction-boundary request and a retire pulse for the enkel top level.

---
 rtl/enkel_core_p_if.sv | 27 ++
 rtl/enkel_core_p.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/enkel_core_p_if.sv
// Memory bus between the enkel core and its instruction/data memory.
// A request is held (req/we/addr/wdata stable) until the cycle in which
// mem_ack is high; ack in the very first request cycle is legal.
//   master (core) : drives mem_req, mem_we, mem_addr, mem_wdata
//                   samples mem_rdata, mem_ack
//   slave (memory): the mirror image
interface enkel_core_p_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/enkel_core_p.sv
// enkel_core_p -- multi-cycle accumulator CPU core.
// Fetches one-word instructions over a req/ack memory bus (any number of
// wait states), executes a 4-bit opcode set on accumulator A with carry and
// zero flags, and can be stopped at an instruction boundary.
// Ports:
//   clk, master_reset_n   clock, asynchronous active-low reset
//   start_computer        leave IDLE/HALTED and fetch from START_ADDR
//   halt_req              go to HALTED instead of FETCH at the next retire
//   in_port               value loaded into A by GET
//   mem                   memory bus (master side)
//   show_out              display register written by SHOW
//   pc_out                program counter
//   status / halted       running (FETCH..MEM_WR) / in HALTED
//   carry, zero           flags
//   instr_done            one-cycle pulse after each retiring edge
module enkel_core_p #(
  parameter int                DATA_W     = 12,
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              master_reset_n,
  input  logic              start_computer,
  input  logic              halt_req,
  input  logic [DATA_W-1:0] in_port,
  enkel_core_p_if.master    mem,
  output logic [DATA_W-1:0] show_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              status,
  output logic              halted,
  output logic              carry,
  output logic              zero,
  output logic              instr_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEM_RD = 3'd3;
  localparam logic [2:0] S_MEM_WR = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_PUT  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_SHOW = 4'h9;
  localparam logic [3:0] OP_GET  = 4'hA;
  localparam logic [3:0] OP_FEED = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d;
  // Only the fields of the instruction word that are ever used are kept;
  // the bits between opcode and operand are don't-care.
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] opd_q, opd_d;
  logic [DATA_W-1:0] show_q, show_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              done_q, done_d;

  logic [DATA_W:0]   add_res;
  logic [DATA_W-1:0] sub_res;
  logic              sub_nb;
  logic              upd_zero;

  assign add_res = {1'b0, a_q} + {1'b0, mem.mem_rdata};
  assign sub_res = a_q - mem.mem_rdata;
  assign sub_nb  = (a_q >= mem.mem_rdata);

  // Bus outputs depend on registered state only, so they are stable for the
  // whole request and collapse to zero the instant reset is asserted.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state_q)
      S_FETCH: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = pc_q;
      end
      S_MEM_RD: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = opd_q;
      end
      S_MEM_WR: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = opd_q;
        mem.mem_wdata = a_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    a_d      = a_q;
    op_d     = op_q;
    opd_d    = opd_q;
    show_d   = show_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    upd_zero = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start_computer) begin
          pc_d    = START_ADDR;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (mem.mem_ack) begin
          op_d    = mem.mem_rdata[DATA_W-1 -: 4];
          opd_d   = mem.mem_rdata[ADDR_W-1:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Register-only instructions execute and retire here; a halt
        // request sampled on this edge diverts to HALTED.
        done_d  = 1'b1;
        state_d = halt_req ? S_HALTED : S_FETCH;
        case (op_q)
          OP_LD, OP_ADD, OP_SUB: begin
            done_d  = 1'b0;
            state_d = S_MEM_RD;
          end
          OP_PUT: begin
            done_d  = 1'b0;
            state_d = S_MEM_WR;
          end
          OP_HALT: state_d = S_HALTED;
          OP_NOT: begin
            a_d      = ~a_q;
            upd_zero = 1'b1;
          end
          OP_JMP: pc_d = opd_q;
          OP_JZ:  if (zero_q)  pc_d = opd_q;
          OP_JC:  if (carry_q) pc_d = opd_q;
          OP_SHOW: show_d = a_q;
          OP_GET: begin
            a_d      = in_port;
            upd_zero = 1'b1;
          end
          OP_FEED: begin
            a_d      = {{(DATA_W-ADDR_W){1'b0}}, opd_q};
            upd_zero = 1'b1;
          end
          default: ; // NOP and the unassigned opcodes C-E
        endcase
      end

      S_MEM_RD: begin
        if (mem.mem_ack) begin
          done_d   = 1'b1;
          state_d  = halt_req ? S_HALTED : S_FETCH;
          upd_zero = 1'b1;
          case (op_q)
            OP_ADD: begin
              a_d     = add_res[DATA_W-1:0];
              carry_d = add_res[DATA_W];
            end
            OP_SUB: begin
              a_d     = sub_res;
              carry_d = sub_nb;   // set when no borrow
            end
            default: a_d = mem.mem_rdata; // LD
          endcase
        end
      end

      S_MEM_WR: begin
        if (mem.mem_ack) begin
          done_d  = 1'b1;
          state_d = halt_req ? S_HALTED : S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (upd_zero) zero_d = (a_d == '0);
  end

  always_ff @(posedge clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= START_ADDR;
      a_q     <= '0;
      op_q    <= '0;
      opd_q   <= '0;
      show_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      op_q    <= op_d;
      opd_q   <= opd_d;
      show_q  <= show_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign show_out   = show_q;
  assign pc_out     = pc_q;
  assign status     = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign halted     = (state_q == S_HALTED);
  assign carry      = carry_q;
  assign zero       = zero_q;
  assign instr_done = done_q;

endmodule
